// File: rtl/video_frame_monitor.sv
`default_nettype none
// video_frame_monitor: per-frame line/pixel/non-zero counter and geometry checker for vsync/href/clken video.
// Optional build macro MONITOR_CRC_EN adds a CRC-16-CCITT of each frame's pixel stream.
module video_frame_monitor #(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_CNT_W = 16,
`ifdef MONITOR_CRC_EN
  parameter logic [15:0] EXP_CRC = 16'h0000,
`endif
  localparam int LW = $clog2(IMG_VDISP + 2),
  localparam int PW = $clog2(IMG_HDISP * IMG_VDISP + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic                   per_frame_clken,
  input  logic [DATA_WIDTH-1:0]  per_img_data,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [LW-1:0]          line_cnt,
  output logic [LW-1:0]          bad_line_cnt,
  output logic [PW-1:0]          nz_pix_cnt,
  output logic                   frame_ok
`ifdef MONITOR_CRC_EN
  ,
  output logic [15:0]            crc_out
`endif
);

  localparam int HW = $clog2(IMG_HDISP + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [HW-1:0] PIX_SAT  = HW'(IMG_HDISP + 1);
  localparam logic [HW-1:0] PIX_EXP  = HW'(IMG_HDISP);
  localparam logic [LW-1:0] LINE_EXP = LW'(IMG_VDISP);
  localparam logic [LW-1:0] LINE_MAX = '1;
  localparam logic [PW-1:0] NZ_MAX   = '1;

  logic [1:0]             state_q, state_d;
  logic                   vs_dly_q, vs_dly_d;
  logic                   hs_dly_q, hs_dly_d;
  logic [HW-1:0]          line_pix_q, line_pix_d;
  logic [LW-1:0]          line_acc_q, line_acc_d;
  logic [LW-1:0]          bad_acc_q, bad_acc_d;
  logic [PW-1:0]          nz_acc_q, nz_acc_d;
  logic [LW-1:0]          line_cnt_q, line_cnt_d;
  logic [LW-1:0]          bad_line_cnt_q, bad_line_cnt_d;
  logic [PW-1:0]          nz_pix_cnt_q, nz_pix_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   frame_ok_q, frame_ok_d;

  logic          vs_rise, hs_fall, pix_vld, pix_nz;
  logic          counting, closing, evt_pix, evt_close;
  logic          crc_ok;
  logic [HW-1:0] line_pix_b, pix_sum;
  logic [LW-1:0] line_acc_b, bad_acc_b;
  logic [PW-1:0] nz_acc_b;

  assign vs_rise   = per_frame_vsync & ~vs_dly_q;
  assign hs_fall   = ~per_frame_href & hs_dly_q;
  assign pix_vld   = per_frame_href & per_frame_clken;
  assign pix_nz    = |per_img_data;
  assign counting  = (state_q != S_IDLE);
  assign closing   = (state_q == S_ACTIVE) & vs_rise;
  assign evt_pix   = counting & pix_vld;
  // A line still open at the closing vsync edge is closed into that frame.
  assign evt_close = counting & (hs_fall | (closing & per_frame_href));
  assign vs_dly_d  = per_frame_vsync;
  assign hs_dly_d  = per_frame_href;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (vs_rise) state_d = S_ACTIVE;
      S_ACTIVE: if (vs_rise) state_d = S_REPORT;
      S_REPORT: state_d = S_ACTIVE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_done = (state_q == S_REPORT);
  end

  // REPORT starts a fresh frame, so its events accumulate from zero.
  always_comb begin
    line_pix_b = '0;
    line_acc_b = '0;
    bad_acc_b  = '0;
    nz_acc_b   = '0;
    if (state_q == S_ACTIVE) begin
      line_pix_b = line_pix_q;
      line_acc_b = line_acc_q;
      bad_acc_b  = bad_acc_q;
      nz_acc_b   = nz_acc_q;
    end

    pix_sum = line_pix_b;
    if (evt_pix && line_pix_b != PIX_SAT) pix_sum = line_pix_b + 1'b1;

    line_pix_d = evt_close ? '0 : pix_sum;
    line_acc_d = line_acc_b;
    if (evt_close && line_acc_b != LINE_MAX) line_acc_d = line_acc_b + 1'b1;
    bad_acc_d = bad_acc_b;
    if (evt_close && pix_sum != PIX_EXP && bad_acc_b != LINE_MAX) bad_acc_d = bad_acc_b + 1'b1;
    nz_acc_d = nz_acc_b;
    if (evt_pix && pix_nz && nz_acc_b != NZ_MAX) nz_acc_d = nz_acc_b + 1'b1;
  end

  always_comb begin
    line_cnt_d     = line_cnt_q;
    bad_line_cnt_d = bad_line_cnt_q;
    nz_pix_cnt_d   = nz_pix_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    frame_ok_d     = frame_ok_q;
    if (closing) begin
      line_cnt_d     = line_acc_d;
      bad_line_cnt_d = bad_acc_d;
      nz_pix_cnt_d   = nz_acc_d;
      frame_cnt_d    = frame_cnt_q + 1'b1;
      frame_ok_d     = (line_acc_d == LINE_EXP) && (bad_acc_d == '0) && crc_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_dly_q       <= 1'b0;
      hs_dly_q       <= 1'b0;
      line_pix_q     <= '0;
      line_acc_q     <= '0;
      bad_acc_q      <= '0;
      nz_acc_q       <= '0;
      line_cnt_q     <= '0;
      bad_line_cnt_q <= '0;
      nz_pix_cnt_q   <= '0;
      frame_cnt_q    <= '0;
      frame_ok_q     <= 1'b0;
    end else begin
      vs_dly_q       <= vs_dly_d;
      hs_dly_q       <= hs_dly_d;
      line_pix_q     <= line_pix_d;
      line_acc_q     <= line_acc_d;
      bad_acc_q      <= bad_acc_d;
      nz_acc_q       <= nz_acc_d;
      line_cnt_q     <= line_cnt_d;
      bad_line_cnt_q <= bad_line_cnt_d;
      nz_pix_cnt_q   <= nz_pix_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_ok_q     <= frame_ok_d;
    end
  end

  assign frame_cnt    = frame_cnt_q;
  assign line_cnt     = line_cnt_q;
  assign bad_line_cnt = bad_line_cnt_q;
  assign nz_pix_cnt   = nz_pix_cnt_q;
  assign frame_ok     = frame_ok_q;

`ifdef MONITOR_CRC_EN
  localparam int BW = ((DATA_WIDTH + 7) / 8) * 8;

  logic [15:0]   crc_q, crc_d, crc_b;
  logic [15:0]   crc_out_q, crc_out_d;
  logic [BW-1:0] pix_pad;

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [BW-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = BW - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  assign pix_pad = BW'(per_img_data);

  always_comb begin
    crc_b     = (state_q == S_ACTIVE) ? crc_q : 16'hFFFF;
    crc_d     = evt_pix ? crc_step(crc_b, pix_pad) : crc_b;
    crc_out_d = closing ? crc_d : crc_out_q;
    crc_ok    = (EXP_CRC == 16'h0000) || (crc_d == EXP_CRC);
  end

  // crc_q holds the CRC seed while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= 16'hFFFF;
      crc_out_q <= '0;
    end else begin
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign crc_out = crc_out_q;
`else
  assign crc_ok = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_frame_monitor.sv
`default_nettype none
// tb_video_frame_monitor: table-driven, randomized and hand-sequenced checks of video_frame_monitor.
module tb_video_frame_monitor;
  localparam int HD = 8, VD = 4, DW = 8, FW = 16, LW = 3, PW = 6;
  localparam int LSAT = 7, NSAT = 63;

  logic clk = 1'b0;
  logic rst, vsync, href, clken;
  logic [DW-1:0] data;
  logic frame_done, frame_ok;
  logic [FW-1:0] frame_cnt;
  logic [LW-1:0] line_cnt, bad_line_cnt;
  logic [PW-1:0] nz_pix_cnt;

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

`ifdef MONITOR_CRC_EN
  function automatic logic [15:0] ramp_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) c = crc_byte(c, 8'(i));
    return c;
  endfunction
  localparam logic [15:0] REF_CRC = ramp_crc();

  logic [15:0] crc_out, crc_out_a, crc_out_b;
  logic done_a, done_b, ok_a, ok_b;
  logic [FW-1:0] fc_a, fc_b;
  logic [LW-1:0] lc_a, lc_b, bc_a, bc_b;
  logic [PW-1:0] nz_a, nz_b;

  video_frame_monitor #(.IMG_HDISP(HD), .IMG_VDISP(VD), .DATA_WIDTH(DW), .FRAME_CNT_W(FW),
                        .EXP_CRC(REF_CRC)) dut_match (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(data), .frame_done(done_a), .frame_cnt(fc_a),
    .line_cnt(lc_a), .bad_line_cnt(bc_a), .nz_pix_cnt(nz_a), .frame_ok(ok_a), .crc_out(crc_out_a));
  video_frame_monitor #(.IMG_HDISP(HD), .IMG_VDISP(VD), .DATA_WIDTH(DW), .FRAME_CNT_W(FW),
                        .EXP_CRC(REF_CRC + 16'd1)) dut_off (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(data), .frame_done(done_b), .frame_cnt(fc_b),
    .line_cnt(lc_b), .bad_line_cnt(bc_b), .nz_pix_cnt(nz_b), .frame_ok(ok_b), .crc_out(crc_out_b));
`endif

  video_frame_monitor #(.IMG_HDISP(HD), .IMG_VDISP(VD), .DATA_WIDTH(DW), .FRAME_CNT_W(FW)
`ifdef MONITOR_CRC_EN
                        , .EXP_CRC(16'h0000)
`endif
  ) dut (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt), .bad_line_cnt(bad_line_cnt),
    .nz_pix_cnt(nz_pix_cnt), .frame_ok(frame_ok)
`ifdef MONITOR_CRC_EN
    , .crc_out(crc_out)
`endif
  );

  typedef struct {
    int nlines; int short_idx; int short_len; int long_idx; int long_len; int mode;
    int e_lines; int e_bad; int e_nz; int e_ok;
  } vec_t;

  int errors = 0, checks = 0, spurious = 0, exp_fcnt = 0;
  int lens[$];
  logic [7:0] pix[$];
  logic [7:0] cur_pix[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    if (href && clken) cur_pix.push_back(data);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_tick();
    tick();
    if (frame_done) spurious++;
  endtask

  task automatic drive_frame(input bit gaps);
    int idx = 0;
    foreach (lens[l]) begin
      href = 1'b1;
      for (int p = 0; p < lens[l]; p++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          clken = 1'b0; data = 8'($urandom); quiet_tick();
        end
        clken = 1'b1; data = pix[idx]; idx++;
        quiet_tick();
      end
      href = 1'b0;
      for (int k = 0; k < 2; k++) begin
        clken = gaps ? 1'($urandom) : 1'b0; data = 8'($urandom);
        quiet_tick();
      end
    end
    clken = 1'b0;
  endtask

  // Called in the cycle after the closing vsync rise has been sampled.
  task automatic check_report(input int l, input int b, input int n, input int ok);
    logic [15:0] c;
    exp_fcnt++;
    check("frame_done", frame_done, 1);
    check("spurious_done", spurious, 0);
    check("frame_cnt", frame_cnt, exp_fcnt);
    check("line_cnt", line_cnt, l);
    check("bad_line_cnt", bad_line_cnt, b);
    check("nz_pix_cnt", nz_pix_cnt, n);
    check("frame_ok", frame_ok, ok);
    c = 16'hFFFF;
    foreach (cur_pix[i]) c = crc_byte(c, cur_pix[i]);
`ifdef MONITOR_CRC_EN
    check("crc_out", crc_out, c);
`endif
    cur_pix.delete();
    spurious = 0;
  endtask

  task automatic close_frame(input int l, input int b, input int n, input int ok);
    vsync = 1'b1; href = 1'b0; clken = 1'b0;
    tick();
    check_report(l, b, n, ok);
    tick();
    check("done_one_cycle", frame_done, 0);
    vsync = 1'b0;
    tick();
  endtask

  task automatic open_after_idle(input string name);
    vsync = 1'b1;
    tick();
    check(name, frame_done, 0);
    tick();
    vsync = 1'b0;
    tick();
    cur_pix.delete();
    spurious = 0;
  endtask

  task automatic build_table(input vec_t v);
    int g = 0;
    lens.delete(); pix.delete();
    for (int l = 0; l < v.nlines; l++) begin
      int len;
      len = (l == v.short_idx) ? v.short_len : (l == v.long_idx) ? v.long_len : HD;
      lens.push_back(len);
      for (int p = 0; p < len; p++) begin
        case (v.mode)
          0:       pix.push_back(8'h01);
          1:       pix.push_back(((l + p) % 2 == 1) ? 8'hFF : 8'h00);
          default: pix.push_back(8'(g));
        endcase
        g++;
      end
    end
  endtask

  task automatic build_clean(input int nlines);
    lens.delete(); pix.delete();
    for (int l = 0; l < nlines; l++) begin
      lens.push_back(HD);
      for (int p = 0; p < HD; p++) pix.push_back(8'h01);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int n, nbad, nnz;
    vecs[0] = '{4, -1, 8, -1, 8, 0, 4, 0, 32, 1};
    vecs[1] = '{4, -1, 8, -1, 8, 0, 4, 0, 32, 1};
    vecs[2] = '{4, -1, 8, -1, 8, 0, 4, 0, 32, 1};
    vecs[3] = '{4,  1, 7,  2, 9, 0, 4, 2, 32, 0};
    vecs[4] = '{5, -1, 8, -1, 8, 1, 5, 0, 20, 0};
    vecs[5] = '{0, -1, 8, -1, 8, 0, 0, 0,  0, 0};
    vecs[6] = '{4, -1, 8, -1, 8, 2, 4, 0, 31, 1};

    rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_bad_line_cnt", bad_line_cnt, 0);
    check("rst_nz_pix_cnt", nz_pix_cnt, 0);
    check("rst_frame_ok", frame_ok, 0);
`ifdef MONITOR_CRC_EN
    check("rst_crc_out", crc_out, 0);
`endif
    rst = 1'b0;
    tick();
    open_after_idle("first_vs_no_done");

    foreach (vecs[i]) begin
      build_table(vecs[i]);
      drive_frame(1'b0);
      close_frame(vecs[i].e_lines, vecs[i].e_bad, vecs[i].e_nz, vecs[i].e_ok);
`ifdef MONITOR_CRC_EN
      if (vecs[i].mode == 2) begin
        check("crc_ramp_ref", crc_out, REF_CRC);
        check("crc_exp_match_ok", ok_a, 1);
        check("crc_exp_off_ok", ok_b, 0);
      end
`endif
    end

    for (int f = 0; f < 20; f++) begin
      lens.delete(); pix.delete();
      n = $urandom_range(0, 9);
      nbad = 0; nnz = 0;
      for (int l = 0; l < n; l++) begin
        int len;
        len = ($urandom_range(0, 1) == 0) ? HD : $urandom_range(5, 11);
        lens.push_back(len);
        if (len != HD) nbad++;
        for (int p = 0; p < len; p++) begin
          logic [7:0] v;
          v = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          pix.push_back(v);
          if (v != 0) nnz++;
        end
      end
      drive_frame(1'b1);
      close_frame((n > LSAT) ? LSAT : n, (nbad > LSAT) ? LSAT : nbad,
                  (nnz > NSAT) ? NSAT : nnz, (n == VD && nbad == 0) ? 1 : 0);
    end

    // href falls on the vsync-rise cycle; a new line starts in the report cycle.
    build_clean(3);
    drive_frame(1'b0);
    href = 1'b1; clken = 1'b1; data = 8'h01;
    repeat (HD) quiet_tick();
    vsync = 1'b1; href = 1'b0; clken = 1'b0;
    tick();
    check_report(4, 0, 32, 1);
    href = 1'b1; clken = 1'b1; data = 8'h01;
    tick();
    check("done_one_cycle_b", frame_done, 0);
    vsync = 1'b0;
    repeat (HD - 1) quiet_tick();
    href = 1'b0; clken = 1'b0;
    repeat (2) quiet_tick();
    build_clean(3);
    drive_frame(1'b0);
    close_frame(4, 0, 32, 1);

    // Last pixel lands on the vsync-rise cycle with href still high.
    build_clean(3);
    drive_frame(1'b0);
    href = 1'b1; clken = 1'b1; data = 8'h01;
    repeat (HD - 1) quiet_tick();
    vsync = 1'b1;
    tick();
    check_report(4, 0, 32, 1);
    data = 8'h05;
    repeat (3) tick();
    check("done_one_cycle_a", frame_done, 0);

    // Reset mid-frame clears outputs at once.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_frame_done", frame_done, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_line_cnt", line_cnt, 0);
    check("midrst_nz_pix_cnt", nz_pix_cnt, 0);
    check("midrst_frame_ok", frame_ok, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
    exp_fcnt = 0;
    repeat (2) tick();
    open_after_idle("rst_vs1_no_done");
    build_clean(4);
    drive_frame(1'b1);
    close_frame(4, 0, 32, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
